// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, per-frame
// scan result and the {row,col} -> hex key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_e;

  typedef struct packed {
    frame_res_e res;
    logic [3:0] code;
  } frame_t;

  // Indexed {row[1:0], col[1:0]}; '*' reads as E and '#' as F.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] first_row(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_sync.sv
// Two-flop synchronizer for asynchronous level inputs; reset value is a
// parameter so idle (pulled-up) lines come out of reset inactive.
module key_sync #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner: column scan, per-frame hit classification and a
// press/release debounce FSM emitting one strobed hex code per accepted press.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       err_multi
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0] row_sync;

  key_sync #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (clear),
    .d     (row_in),
    .q     (row_sync)
  );

  // ---------------- scan + frame accumulation ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       acc_hits_q, acc_hits_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic             dwell_end, frame_end;
  logic [3:0]       col_hits;
  logic [2:0]       col_pc, hit_sum;
  logic [3:0]       col_code;
  frame_t           fr;

  always_comb begin
    dwell_end  = (div_q == DIV_LAST);
    frame_end  = dwell_end && (col_q == 2'd3);
    col_hits   = ~row_sync;
    col_pc     = popcnt4(col_hits);
    col_code   = KEY_MAP[{first_row(col_hits), col_q}];
    hit_sum    = {1'b0, acc_hits_q} + col_pc;

    fr.res  = (hit_sum == 3'd0) ? FR_NONE : (hit_sum == 3'd1) ? FR_SINGLE : FR_MULTI;
    fr.code = (col_pc == 3'd1) ? col_code : acc_code_q;

    div_d      = dwell_end ? '0 : div_q + DIV_W'(1);
    col_d      = dwell_end ? col_q + 2'd1 : col_q;
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_hits_d = 2'd0;
      acc_code_d = 4'h0;
    end else if (dwell_end) begin
      // Saturate at 2: anything beyond "more than one" is just MULTI.
      acc_hits_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      if (col_pc == 3'd1) acc_code_d = col_code;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      div_q      <= '0;
      col_q      <= 2'd0;
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'h0;
    end else begin
      div_q      <= div_d;
      col_q      <= col_d;
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  // ---------------- debounce FSM ----------------
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             err_multi_q, err_multi_d;
  logic             press, accept;
  logic [3:0]       accept_code;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    err_multi_d = 1'b0;
    accept      = 1'b0;
    accept_code = cand_q;
    press       = (fr.res == FR_SINGLE);
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    if (frame_end) begin
      err_multi_d = (fr.res == FR_MULTI);
      unique case (state_q)
        IDLE: begin
          if (press) begin
            cand_d = fr.code;
            cnt_d  = CNT_W'(1);
            if (CNT_MAX == CNT_W'(1)) begin
              accept      = 1'b1;
              accept_code = fr.code;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!press) begin
            state_d = IDLE;
          end else if (fr.code != cand_q) begin
            cand_d = fr.code;
            cnt_d  = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) accept = 1'b1;
          end
        end
        HELD: begin
          // Any press, even a different key, just keeps the hold alive.
          if (!press) begin
            cnt_d = CNT_W'(1);
            if (CNT_MAX == CNT_W'(1)) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (press) begin
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        state_d     = HELD;
        key_code_d  = accept_code;
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Frame-level self-checking bench for keypad_entry: a switch-matrix keypad
// model, directed scenarios, then random key patterns against a streak model.
module tb_keypad_entry;

  localparam int SD    = 4;
  localparam int DS    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] row_in, col_out, key_code;
  logic       key_valid, key_down, err_multi;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r / column c pressed

  int total = 0;
  int bad   = 0;

  // Reference model state: streak counts per frame.
  bit         m_down;
  logic [3:0] m_code;
  logic [3:0] m_last;
  int         m_run;
  int         m_rel;

  logic [3:0] layout [4][4];

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk       (clk),
    .clear     (clear),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows are pulled up.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_down = 1'b0;
    m_code = 4'h0;
    m_last = 4'h0;
    m_run  = 0;
    m_rel  = 0;
  endtask

  function automatic logic [3:0] code_of(input logic [15:0] k);
    logic [3:0] kc;
    kc = 4'h0;
    for (int i = 0; i < 16; i++)
      if (k[i]) kc = layout[i/4][i%4];
    return kc;
  endfunction

  task automatic model_frame(input logic [15:0] k, output bit strobe, output bit multi);
    int         n;
    logic [3:0] kc;
    n      = $countones(k);
    multi  = (n > 1);
    strobe = 1'b0;
    kc     = code_of(k);
    if (!m_down) begin
      if (n == 1) begin
        m_run  = (m_run > 0 && kc == m_last) ? m_run + 1 : 1;
        m_last = kc;
        if (m_run >= DS) begin
          strobe = 1'b1;
          m_down = 1'b1;
          m_code = kc;
          m_rel  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 1) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel >= DS) begin
          m_down = 1'b0;
          m_run  = 0;
        end
      end
    end
  endtask

  // Called at a negedge aligned with a frame start; returns at the negedge
  // right after that frame's end edge.
  task automatic run_frame(input logic [15:0] k);
    bit         s, m;
    logic [3:0] ec;
    keys = k;
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge clk);
      @(negedge clk);
      ec = ~(4'b0001 << ((j % FRAME) / SD));
      if (j == FRAME) model_frame(k, s, m);
      else begin
        s = 1'b0;
        m = 1'b0;
      end
      chk("col_out",   col_out,   ec);
      chk("key_valid", key_valid, s);
      chk("err_multi", err_multi, m);
      chk("key_down",  key_down,  m_down);
      chk("key_code",  key_code,  m_code);
    end
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_frame(k);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},   col_out,   4'b1110);
    chk({tag, "_code"},  key_code,  4'h0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_down"},  key_down,  1'b0);
    chk({tag, "_err"},   err_multi, 1'b0);
  endtask

  localparam logic [15:0] K8  = 16'h0001 << 9;   // r2/c1
  localparam logic [15:0] K1  = 16'h0001 << 0;   // r0/c0
  localparam logic [15:0] K0  = 16'h0001 << 13;  // r3/c1
  localparam logic [15:0] K3  = 16'h0001 << 2;   // r0/c2
  localparam logic [15:0] K5  = 16'h0001 << 5;   // r1/c1
  localparam logic [15:0] K6  = 16'h0001 << 6;   // r1/c2

  initial begin
    logic [15:0] cur;
    layout[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
    layout[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
    layout[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
    layout[3] = '{4'hE, 4'h0, 4'hF, 4'hD};
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    clear = 1'b1;

    // Accept '8' so key_code is non-zero, release, then start a new debounce.
    frames(K8, 2);
    frames(16'h0, 2);
    run_frame(K8);
    keys = K8;
    repeat (6) @(negedge clk);
    #2 clear = 1'b0;
    #1 chk_reset_vals("async_rst");
    keys = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_hold");
    clear = 1'b1;
    model_reset();
    frames(16'h0, 3);

    // Press and hold '8', then bounce on '1'.
    frames(K8, 6);
    run_frame(16'h0);
    run_frame(K8);
    frames(K8, 2);
    frames(16'h0, 2);
    run_frame(K0);
    run_frame(K0);
    frames(16'h0, 2);
    run_frame(K1);
    run_frame(16'h0);
    run_frame(K1);
    frames(16'h0, 2);

    // Two keys in one row, then slide between keys while held.
    frames(K1 | K3, 3);
    frames(16'h0, 2);
    frames(K5, 2);
    frames(K6, 3);
    frames(16'h0, 2);
    frames(K6, 2);
    frames(16'h0, 2);

    cur = 16'h0;
    repeat (120) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: ;
        5, 6:          cur = 16'h0;
        7, 8:          cur = 16'h0001 << $urandom_range(0, 15);
        default:       cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      run_frame(cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
